// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_gen
// Purpose : Raster timing generator. Walks a (PIXEL_X, LINE_Y) position over
//           an H_TOTAL x V_TOTAL frame and presents registered sync/blank
//           strobes, character-cell coordinates and line/frame start pulses,
//           all describing the same position with zero relative skew.
// Ports   : CLK           - clock, rising edge
//           RST           - asynchronous active-low reset
//           CE            - pixel enable; position advances only when high
//           SCAN_EN       - low parks the generator at the origin
//           HSYNC/VSYNC   - syncs, active level HS_POL/VS_POL
//           BLANK         - composite blanking
//           PIXEL_X/LINE_Y- current position
//           SUBCHAR_PIXEL/SUBCHAR_LINE - position within a character cell
//           CHAR_COLUMN/CHAR_LINE      - character cell coordinates
//           LINE_START/FRAME_START     - one-CLK pulses on line/frame origin
// Revision: 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 8,
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int CW       = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          SCAN_EN,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          BLANK,
  output logic [HW-1:0] PIXEL_X,
  output logic [VW-1:0] LINE_Y,
  output logic [2:0]    SUBCHAR_PIXEL,
  output logic [2:0]    SUBCHAR_LINE,
  output logic [CW-1:0] CHAR_COLUMN,
  output logic [CW-1:0] CHAR_LINE,
  output logic          LINE_START,
  output logic          FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [2:0]    CW_LAST = 3'(CHAR_W - 1);
  localparam logic [2:0]    CH_LAST = 3'(CHAR_H - 1);

  // Decode boundaries kept at 32 bits so a sync ending exactly at 2^HW
  // does not truncate to zero.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  // run_q distinguishes the parked origin (after reset / SCAN_EN low) from
  // a live (0,0): the first enabled edge out of park presents (0,0) with
  // pulses instead of advancing to (1,0).
  logic          run_q,    run_d;
  logic [HW-1:0] px_q,     px_d;
  logic [VW-1:0] ly_q,     ly_d;
  logic [2:0]    sub_px_q, sub_px_d;
  logic [2:0]    sub_ln_q, sub_ln_d;
  logic [CW-1:0] col_q,    col_d;
  logic [CW-1:0] row_q,    row_d;
  logic          hs_q,     hs_d;
  logic          vs_q,     vs_d;
  logic          blank_q,  blank_d;
  logic          ls_q,     ls_d;
  logic          fs_q,     fs_d;

  logic h_wrap, v_wrap, sub_px_wrap, sub_ln_wrap;

  assign h_wrap      = (px_q == H_LAST);
  assign v_wrap      = (ly_q == V_LAST);
  assign sub_px_wrap = (sub_px_q == CW_LAST);
  assign sub_ln_wrap = (sub_ln_q == CH_LAST);

  always_comb begin
    run_d    = run_q;
    px_d     = px_q;
    ly_d     = ly_q;
    sub_px_d = sub_px_q;
    sub_ln_d = sub_ln_q;
    col_d    = col_q;
    row_d    = row_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    // Pulses last a single CLK regardless of CE.
    ls_d     = 1'b0;
    fs_d     = 1'b0;

    if (CE) begin
      if (!SCAN_EN) begin
        run_d    = 1'b0;
        px_d     = '0;
        ly_d     = '0;
        sub_px_d = '0;
        sub_ln_d = '0;
        col_d    = '0;
        row_d    = '0;
      end else if (!run_q) begin
        run_d    = 1'b1;
        px_d     = '0;
        ly_d     = '0;
        sub_px_d = '0;
        sub_ln_d = '0;
        col_d    = '0;
        row_d    = '0;
        ls_d     = 1'b1;
        fs_d     = 1'b1;
      end else if (h_wrap) begin
        px_d     = '0;
        sub_px_d = '0;
        col_d    = '0;
        ls_d     = 1'b1;
        if (v_wrap) begin
          ly_d     = '0;
          sub_ln_d = '0;
          row_d    = '0;
          fs_d     = 1'b1;
        end else begin
          ly_d = ly_q + VW'(1);
          if (sub_ln_wrap) begin
            sub_ln_d = '0;
            row_d    = row_q + CW'(1);
          end else begin
            sub_ln_d = sub_ln_q + 3'd1;
          end
        end
      end else begin
        px_d = px_q + HW'(1);
        if (sub_px_wrap) begin
          sub_px_d = '0;
          col_d    = col_q + CW'(1);
        end else begin
          sub_px_d = sub_px_q + 3'd1;
        end
      end

      // Strobes are decoded from the next position so they register in
      // the same edge as the counters they describe.
      if (run_d) begin
        hs_d    = ((32'(px_d) >= HS_START) && (32'(px_d) < HS_END)) ? HS_ON : ~HS_ON;
        vs_d    = ((32'(ly_d) >= VS_START) && (32'(ly_d) < VS_END)) ? VS_ON : ~VS_ON;
        blank_d = (32'(px_d) >= H_ACT_END) || (32'(ly_d) >= V_ACT_END);
      end else begin
        hs_d    = ~HS_ON;
        vs_d    = ~VS_ON;
        blank_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q    <= 1'b0;
      px_q     <= '0;
      ly_q     <= '0;
      sub_px_q <= '0;
      sub_ln_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hs_q     <= ~HS_ON;
      vs_q     <= ~VS_ON;
      blank_q  <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      run_q    <= run_d;
      px_q     <= px_d;
      ly_q     <= ly_d;
      sub_px_q <= sub_px_d;
      sub_ln_q <= sub_ln_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign HSYNC         = hs_q;
  assign VSYNC         = vs_q;
  assign BLANK         = blank_q;
  assign PIXEL_X       = px_q;
  assign LINE_Y        = ly_q;
  assign SUBCHAR_PIXEL = sub_px_q;
  assign SUBCHAR_LINE  = sub_ln_q;
  assign CHAR_COLUMN   = col_q;
  assign CHAR_LINE     = row_q;
  assign LINE_START    = ls_q;
  assign FRAME_START   = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_timing_gen
// Purpose : Self-checking bench for video_timing_gen on a small 16x8 raster.
//           A position-level model (integer x/y, mod/div arithmetic) predicts
//           every output each cycle; literal expectations pin the model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HS_POL = 0, VS_POL = 1, CHAR_W = 4, CHAR_H = 2;
  localparam int HW = 11, VW = 10, CW = 7;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          scan_en = 1'b0;
  logic          hsync, vsync, blank, line_start, frame_start;
  logic [HW-1:0] pixel_x;
  logic [VW-1:0] line_y;
  logic [2:0]    sub_px, sub_ln;
  logic [CW-1:0] char_col, char_row;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
    .HW(HW), .VW(VW), .CW(CW)
  ) dut (
    .CLK(clk), .RST(rst_n), .CE(ce), .SCAN_EN(scan_en),
    .HSYNC(hsync), .VSYNC(vsync), .BLANK(blank),
    .PIXEL_X(pixel_x), .LINE_Y(line_y),
    .SUBCHAR_PIXEL(sub_px), .SUBCHAR_LINE(sub_ln),
    .CHAR_COLUMN(char_col), .CHAR_LINE(char_row),
    .LINE_START(line_start), .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: parked flag, integer position, pulse flags.
  int m_run = 0, m_px = 0, m_py = 0, m_ls = 0, m_fs = 0;
  // Tallies over a window of cycles.
  int t_fs = 0, t_ls = 0, t_hs0 = 0, t_vs1 = 0, t_bl = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t x=%0d y=%0d)", name, act, exp, $time, m_px, m_py);
    end
  endtask

  task automatic model_park();
    m_run = 0; m_px = 0; m_py = 0; m_ls = 0; m_fs = 0;
  endtask

  task automatic model_edge(input bit c, input bit s);
    m_ls = 0; m_fs = 0;
    if (rst_n && c) begin
      if (!s) begin
        m_run = 0; m_px = 0; m_py = 0;
      end else if (m_run == 0) begin
        m_run = 1; m_px = 0; m_py = 0; m_ls = 1; m_fs = 1;
      end else begin
        m_px = (m_px + 1) % HT;
        if (m_px == 0) begin
          m_py = (m_py + 1) % VT;
          m_ls = 1;
          m_fs = (m_py == 0) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int e_hs, e_vs, e_bl;
    if (m_run == 0) begin
      e_hs = 1 - HS_POL; e_vs = 1 - VS_POL; e_bl = 1;
    end else begin
      e_hs = (m_px >= H_ACTIVE + H_FP && m_px < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : 1 - HS_POL;
      e_vs = (m_py >= V_ACTIVE + V_FP && m_py < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : 1 - VS_POL;
      e_bl = (m_px >= H_ACTIVE || m_py >= V_ACTIVE) ? 1 : 0;
    end
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("blank", int'(blank), e_bl);
    chk("pixel_x", int'(pixel_x), m_px);
    chk("line_y", int'(line_y), m_py);
    chk("subchar_pixel", int'(sub_px), m_px % CHAR_W);
    chk("char_column", int'(char_col), (m_px / CHAR_W) % (1 << CW));
    chk("subchar_line", int'(sub_ln), m_py % CHAR_H);
    chk("char_line", int'(char_row), (m_py / CHAR_H) % (1 << CW));
    chk("line_start", int'(line_start), m_ls);
    chk("frame_start", int'(frame_start), m_fs);
  endtask

  task automatic clear_tally();
    t_fs = 0; t_ls = 0; t_hs0 = 0; t_vs1 = 0; t_bl = 0;
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge.
  task automatic cyc(input bit c, input bit s);
    ce = c; scan_en = s;
    @(posedge clk);
    model_edge(c, s);
    @(negedge clk);
    compare_all();
    t_fs  += int'(frame_start);
    t_ls  += int'(line_start);
    t_hs0 += (hsync == 1'b0) ? 1 : 0;
    t_vs1 += (vsync == 1'b1) ? 1 : 0;
    t_bl  += int'(blank);
  endtask

  initial begin
    int found;
    int r;
    bit rc, rs;

    // Reset state
    model_park();
    @(negedge clk); @(negedge clk);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_pixel_x", int'(pixel_x), 0);
    chk("rst_pulses", int'(line_start) + int'(frame_start), 0);
    compare_all();
    rst_n = 1'b1;

    // First edge after reset release presents (0,0) with both pulses
    cyc(1'b1, 1'b1);
    chk("first_ls", int'(line_start), 1);
    chk("first_fs", int'(frame_start), 1);
    chk("first_blank", int'(blank), 0);
    chk("first_px", int'(pixel_x), 0);
    for (int i = 2; i <= 16; i++) cyc(1'b1, 1'b1);
    chk("edge16_px", int'(pixel_x), 15);
    chk("edge16_py", int'(line_y), 0);
    cyc(1'b1, 1'b1);
    chk("edge17_px", int'(pixel_x), 0);
    chk("edge17_py", int'(line_y), 1);
    chk("edge17_ls", int'(line_start), 1);

    // Full frame sweep
    clear_tally();
    for (int i = 0; i < HT * VT; i++) cyc(1'b1, 1'b1);
    chk("frame_fs_count", t_fs, 1);
    chk("frame_hsync_low", t_hs0, 24);
    chk("frame_vsync_high", t_vs1, 32);
    chk("frame_blank_count", t_bl, 96);

    // Character cell coordinates at (13,5)
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc(1'b1, 1'b1);
      if (m_px == 13 && m_py == 5) found = 1;
    end
    chk("reach_13_5", found, 1);
    chk("cell_subchar_pixel", int'(sub_px), 1);
    chk("cell_char_column", int'(char_col), 3);
    chk("cell_subchar_line", int'(sub_ln), 1);
    chk("cell_char_line", int'(char_row), 2);

    // CE one-in-three: 16 CE edges cover exactly one line wrap
    clear_tally();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    end
    chk("ce_third_ls_cycles", t_ls, 1);

    // Async reset while HSYNC is active
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      cyc(1'b1, 1'b1);
      if (m_px == 11) found = 1;
    end
    chk("reach_px11", found, 1);
    ce = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b1);
    #2;
    chk("hsync_before_rst", int'(hsync), 0);
    rst_n = 1'b0;
    model_park();
    #1;
    chk("hsync_async_rst", int'(hsync), 1);
    chk("blank_async_rst", int'(blank), 1);
    @(negedge clk);
    compare_all();
    cyc(1'b1, 1'b1);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);
    chk("post_rst_fs", int'(frame_start), 1);

    // SCAN_EN drop at line 6
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc(1'b1, 1'b1);
      if (m_py == 6) found = 1;
    end
    chk("reach_ly6", found, 1);
    clear_tally();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk("park_blank", int'(blank), 1);
    end
    chk("park_no_pulses", t_fs + t_ls, 0);
    cyc(1'b1, 1'b1);
    chk("unpark_fs", int'(frame_start), 1);
    chk("unpark_px", int'(pixel_x), 0);
    chk("unpark_py", int'(line_y), 0);

    // Randomized CE / SCAN_EN with occasional mid-cycle async resets
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 199));
      rc = ($urandom_range(0, 99) < 70);
      rs = ($urandom_range(0, 99) < 97);
      if (r == 0) begin
        #2;
        rst_n = 1'b0;
        model_park();
        cyc(rc, rs);
        rst_n = 1'b1;
      end else begin
        cyc(rc, rs);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
